// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, programmable bit divisor and a "drained" IRQ.
// Define UART_TX_PARITY_EN to add an optional even-parity bit selected by CTRL[2].
module uart_tx_dev #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DIV_DEFAULT = 16'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        tx
);

    localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [6:0] DEPTH_C = 7'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [6:0]    count;
    logic          ovf;
    logic          en;
    logic          irq_en;
    logic          parity_en;
    logic [15:0]   divisor;

    logic [2:0]    state;
    logic [15:0]   bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
`ifdef UART_TX_PARITY_EN
    logic          par_bit;
    logic          par_mode;
`endif

    logic [1:0]    sel;
    logic          wr_data;
    logic          wr_status;
    logic          wr_ctrl;
    logic          wr_div;
    logic          empty;
    logic          full;
    logic          busy;
    logic          pop;
    logic          push_ok;
    logic          bit_end;
    logic          can_pop;
    logic [15:0]   d_eff;
    logic [7:0]    head;
    logic          tx_next;
    logic          unused_bits;

    assign unused_bits = ^{Addr[29:2], Din[31:16]};

    assign sel       = Addr[1:0];
    assign wr_data   = WE && (sel == 2'd0);
    assign wr_status = WE && (sel == 2'd1);
    assign wr_ctrl   = WE && (sel == 2'd2);
    assign wr_div    = WE && (sel == 2'd3);

    assign empty   = (count == 7'd0);
    assign full    = (count == DEPTH_C);
    assign busy    = (state != S_IDLE);
    assign d_eff   = (divisor == 16'd0) ? 16'd1 : divisor;
    assign head    = fifo_mem[rd_ptr];
    assign bit_end = (bit_cnt == 16'd0);
    assign can_pop = en && !empty;

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign pop     = ((state == S_IDLE) && can_pop) || ((state == S_STOP) && bit_end && can_pop);
    assign push_ok = wr_data && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= Din[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 7'd0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + {6'd0, push_ok} - {6'd0, pop};
            if (wr_status)                   ovf <= 1'b0;
            else if (wr_data && full && !pop) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en      <= 1'b0;
            irq_en  <= 1'b0;
            divisor <= DIV_DEFAULT;
        end else begin
            if (wr_ctrl) begin
                en     <= Din[0];
                irq_en <= Din[1];
            end
            if (wr_div) divisor <= Din[15:0];
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset)        parity_en <= 1'b0;
        else if (wr_ctrl) parity_en <= Din[2];
    end
`else
    assign parity_en = 1'b0;
`endif

    // bit_cnt is loaded only at bit boundaries, so a DIVISOR change never stretches or cuts the current bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
            par_mode <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state   <= S_START;
                        shift   <= head;
                        bit_cnt <= d_eff - 16'd1;
`ifdef UART_TX_PARITY_EN
                        par_bit  <= ^head;
                        par_mode <= parity_en;
`endif
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state   <= S_DATA;
                        bit_idx <= 3'd0;
                        bit_cnt <= d_eff - 16'd1;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= d_eff - 16'd1;
                        shift   <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= par_mode ? S_PARITY : S_STOP;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        state   <= S_STOP;
                        bit_cnt <= d_eff - 16'd1;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            state   <= S_START;
                            shift   <= head;
                            bit_cnt <= d_eff - 16'd1;
`ifdef UART_TX_PARITY_EN
                            par_bit  <= ^head;
                            par_mode <= parity_en;
`endif
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_next = 1'b1;
        case (state)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shift[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_next = par_bit;
`endif
            default:  tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx  <= 1'b1;
            IRQ <= 1'b0;
        end else begin
            tx  <= tx_next;
            IRQ <= irq_en && empty && !busy;
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (sel)
            2'd1:    Dout = {22'd0, ovf, busy, full, empty, count[5:0]};
            2'd2:    Dout = {29'd0, parity_en, irq_en, en};
            2'd3:    Dout = {16'd0, divisor};
            default: Dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed bench for uart_tx_dev: expected line bits are queued at each DATA store and
// compared cycle by cycle against tx when the frame appears.
module tb_uart_tx_dev;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;
    logic        tx;

    uart_tx_dev #(.FIFO_DEPTH(8), .DIV_DEFAULT(16'd16)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    int          ntests = 0;
    int          nfail  = 0;
    logic [0:0]  exp_q[$];
    int          bit_d [0:10];
    int          act_n = 0;
    int          act_k [2];
    int          act_j [2];
    logic [29:0] act_a [2];
    logic [31:0] act_v [2];
    int          busy_cnt;
    int          irq_hi;
    logic [7:0]  b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rd_check(input string tag, input logic [29:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        check(tag, Dout, exp);
    endtask

    // Called at a negedge; the store lands on the following posedge.
    task automatic do_write(input logic [29:0] a, input logic [31:0] v);
        Addr = a;
        Din  = v;
        WE   = 1'b1;
        @(negedge clk);
        WE   = 1'b0;
        Addr = 30'd1;
    endtask

    task automatic push_frame(input logic [7:0] v, input bit par);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(v[i]);
        if (par) exp_q.push_back(^v);
        exp_q.push_back(1'b1);
    endtask

    task automatic set_d(input int d);
        for (int i = 0; i < 11; i++) bit_d[i] = d;
    endtask

    task automatic wait_start();
        int n = 0;
        while (tx !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", tx, 0);
    endtask

    // Entered at the negedge of the first start-bit cycle; leaves at the negedge just past the stop bit.
    task automatic capture_frame(input int nb);
        logic e;
        Addr = 30'd1;
        for (int k = 0; k < nb; k++) begin
            if (exp_q.size() == 0) begin
                check("q_underflow", 0, 1);
                e = 1'b1;
            end else begin
                e = exp_q.pop_front();
            end
            for (int j = 0; j < bit_d[k]; j++) begin
                check($sformatf("bit%0d_cyc%0d", k, j), tx, e);
                if (Addr == 30'd1) busy_cnt += int'(Dout[8]);
                irq_hi += int'(IRQ);
                WE   = 1'b0;
                Addr = 30'd1;
                for (int a = 0; a < act_n; a++) begin
                    if (k == act_k[a] && j == act_j[a]) begin
                        Addr = act_a[a];
                        Din  = act_v[a];
                        WE   = 1'b1;
                    end
                end
                @(negedge clk);
            end
        end
        WE   = 1'b0;
        Addr = 30'd1;
    endtask

    initial begin
        reset = 1'b1;
        WE    = 1'b0;
        Addr  = 30'd1;
        Din   = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // reset state
        check("rst_tx", tx, 1);
        check("rst_irq", IRQ, 0);
        rd_check("rst_status", 30'd1, 32'h40);
        rd_check("rst_ctrl", 30'd2, 32'h0);
        rd_check("rst_div", 30'd3, 32'd16);
        rd_check("rst_data", 30'd0, 32'h0);

        // test 1: single frame 0x55 at D=4, latency and busy width
        do_write(30'd3, 32'hABCD0004);
        rd_check("t1_div_mask", 30'd3, 32'h4);
        do_write(30'd2, 32'h1);
        push_frame(8'h55, 1'b0);
        do_write(30'd0, 32'h55);
        check("t1_tx_idle0", tx, 1);
        rd_check("t1_pre_pop", 30'd1, 32'h001);
        @(negedge clk);
        check("t1_tx_idle1", tx, 1);
        rd_check("t1_popped", 30'd1, 32'h140);
        busy_cnt = int'(Dout[8]);
        irq_hi   = 0;
        @(negedge clk);
        set_d(4);
        capture_frame(10);
        check("t1_busy_cycles", busy_cnt, 40);
        check("t1_tx_end", tx, 1);
        rd_check("t1_status_end", 30'd1, 32'h40);

        // test 2: overflow, ovf clear, push+pop while full, back-to-back frames
        do_write(30'd2, 32'h0);
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i < 8) push_frame(b, 1'b0);
            do_write(30'd0, {24'd0, b});
        end
        rd_check("t2_full_ovf", 30'd1, 32'h288);
        do_write(30'd1, 32'h0);
        rd_check("t2_ovf_clr", 30'd1, 32'h088);
        do_write(30'd2, 32'h1);
        b = 8'($urandom_range(0, 255));
        push_frame(b, 1'b0);
        do_write(30'd0, {24'd0, b});
        rd_check("t2_pushpop_full", 30'd1, 32'h188);
        wait_start();
        set_d(4);
        for (int i = 0; i < 9; i++) begin
            capture_frame(10);
            if (i < 8) check("t2_no_gap", tx, 0);
        end
        check("t2_tx_end", tx, 1);
        check("t2_q_drained", exp_q.size(), 0);

        // test 3: IRQ drop on store and reassert after stop
        do_write(30'd3, 32'd2);
        do_write(30'd2, 32'h3);
        repeat (2) @(negedge clk);
        check("t3_irq_idle", IRQ, 1);
        push_frame(8'hA5, 1'b0);
        do_write(30'd0, 32'hA5);
        @(negedge clk);
        check("t3_irq_drop", IRQ, 0);
        @(negedge clk);
        irq_hi = 0;
        set_d(2);
        capture_frame(10);
        check("t3_irq_low_in_frame", irq_hi, 0);
        check("t3_irq_back", IRQ, 1);
        do_write(30'd2, 32'h1);
        @(negedge clk);
        check("t3_irq_off", IRQ, 0);

        // test 4: DIVISOR change in data bit 3, en cleared mid-frame with a byte queued
        do_write(30'd2, 32'h0);
        do_write(30'd3, 32'd8);
        push_frame(8'h00, 1'b0);
        do_write(30'd0, 32'h00);
        do_write(30'd0, 32'h3C);
        do_write(30'd2, 32'h1);
        wait_start();
        for (int k = 0; k < 11; k++) bit_d[k] = (k <= 4) ? 8 : 2;
        act_n = 2;
        act_k[0] = 4; act_j[0] = 1; act_a[0] = 30'd3; act_v[0] = 32'd2;
        act_k[1] = 6; act_j[1] = 0; act_a[1] = 30'd2; act_v[1] = 32'd0;
        capture_frame(10);
        act_n = 0;
        check("t4_tx_end", tx, 1);
        rd_check("t4_idle_count1", 30'd1, 32'h001);

        // test 5: reset in the middle of DATA, then DIVISOR=0
        do_write(30'd2, 32'h1);
        wait_start();
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_tx", tx, 1);
        check("t5_irq", IRQ, 0);
        rd_check("t5_status", 30'd1, 32'h40);
        rd_check("t5_div", 30'd3, 32'd16);
        rd_check("t5_ctrl", 30'd2, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        do_write(30'd3, 32'd0);
        do_write(30'd2, 32'h1);
        push_frame(8'h96, 1'b0);
        do_write(30'd0, 32'h96);
        wait_start();
        set_d(1);
        capture_frame(10);
        check("t5_tx_end", tx, 1);

        // test 6: parity control
        do_write(30'd3, 32'd1);
        do_write(30'd2, 32'h5);
        rd_check("t6_ctrl", 30'd2, PAR ? 32'h5 : 32'h1);
        push_frame(8'h07, PAR);
        do_write(30'd0, 32'h07);
        wait_start();
        set_d(1);
        capture_frame(PAR ? 11 : 10);
        check("t6_tx_end", tx, 1);
        check("t6_q_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
